// File: rtl/sdram_pll_phase_ctrl_if.sv
// Step-request handshake between a phase-calibration master and
// sdram_pll_phase_ctrl: request fields, ready, and done/err completion pulses.
interface sdram_pll_phase_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_sel;
    logic       req_dir;
    logic [5:0] req_steps;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_sel, req_dir, req_steps,
        input  req_ready, done, err
    );

    modport slave (
        input  req_valid, req_sel, req_dir, req_steps,
        output req_ready, done, err
    );
endinterface

// File: rtl/sdram_pll_phase_ctrl.sv
// PLLA dynamic phase-shift controller: turns step requests into spaced
// PSPULSE trains on PSSEL/PSDIR and tracks a modulo phase position per output.
// Optional abort input is compiled in with `define SDRAM_PHASE_CTRL_ABORT_EN.
module sdram_pll_phase_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int PHASE_STEPS = 48,
    parameter int INIT_POS0   = 0,
    parameter int INIT_POS1   = 30,
    parameter int INIT_POS2   = 36,
    parameter int SETUP_CYC   = 4,
    parameter int PULSE_HI    = 4,
    parameter int PULSE_GAP   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sdram_pll_phase_ctrl_if.slave   req,
`ifdef SDRAM_PHASE_CTRL_ABORT_EN
    input  logic                    abort,
`endif
    output logic [NUM_CH*6-1:0]     phase_pos,
    output logic [2:0]              ps_sel,
    output logic                    ps_dir,
    output logic                    ps_pulse
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] PHI   = 3'd2;
    localparam logic [2:0] PLO   = 3'd3;
    localparam logic [2:0] FIN   = 3'd4;

    logic [2:0]              state;
    logic [7:0]              cnt;
    logic [5:0]              steps_left;
    logic [2:0]              sel_q;
    logic                    dir_q;
    logic                    rej;
    logic                    abort_pend;
    logic                    abort_in;
    logic [NUM_CH-1:0][5:0]  pos;

`ifdef SDRAM_PHASE_CTRL_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    function automatic logic [5:0] init_of(input int unsigned ch);
        case (ch)
            0:       return 6'(INIT_POS0);
            1:       return 6'(INIT_POS1);
            2:       return 6'(INIT_POS2);
            default: return '0;
        endcase
    endfunction

    function automatic logic [5:0] step_pos(input logic [5:0] p, input logic d);
        if (d)
            return (p == '0) ? 6'(PHASE_STEPS - 1) : p - 6'd1;
        return (p == 6'(PHASE_STEPS - 1)) ? '0 : p + 6'd1;
    endfunction

    // Sequencer: handshake, setup window, pulse high/low timing, completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            steps_left <= '0;
            sel_q      <= '0;
            dir_q      <= 1'b0;
            rej        <= 1'b0;
            abort_pend <= 1'b0;
            ps_sel     <= '0;
            ps_dir     <= 1'b0;
            for (int unsigned ch = 0; ch < NUM_CH; ch++)
                pos[ch] <= init_of(ch);
        end else begin
            case (state)
                IDLE: begin
                    cnt        <= '0;
                    abort_pend <= 1'b0;
                    if (req.req_valid) begin
                        sel_q      <= req.req_sel;
                        dir_q      <= req.req_dir;
                        steps_left <= req.req_steps;
                        rej        <= (32'(req.req_sel) >= NUM_CH);
                        if (32'(req.req_sel) >= NUM_CH || req.req_steps == '0) begin
                            state <= FIN;
                        end else begin
                            ps_sel <= req.req_sel;
                            ps_dir <= req.req_dir;
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (abort_in) begin
                        ps_sel <= '0;
                        ps_dir <= 1'b0;
                        state  <= FIN;
                    end else if (cnt == 8'(SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= PHI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PHI: begin
                    if (abort_in)
                        abort_pend <= 1'b1;
                    if (cnt == 8'(PULSE_HI - 1)) begin
                        cnt        <= '0;
                        steps_left <= steps_left - 6'd1;
                        state      <= PLO;
                        for (int unsigned ch = 0; ch < NUM_CH; ch++)
                            if (32'(sel_q) == ch)
                                pos[ch] <= step_pos(pos[ch], dir_q);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                PLO: begin
                    if (abort_in)
                        abort_pend <= 1'b1;
                    if (cnt == 8'(PULSE_GAP - 1)) begin
                        cnt <= '0;
                        if (steps_left == '0 || abort_pend || abort_in) begin
                            ps_sel <= '0;
                            ps_dir <= 1'b0;
                            state  <= FIN;
                        end else begin
                            state <= PHI;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        req.req_ready = (state == IDLE);
        req.done      = (state == FIN);
        req.err       = (state == FIN) && rej;
        ps_pulse      = (state == PHI);
        phase_pos     = pos;
    end

endmodule
